// File: rtl/line_peak_streamer_if.sv
// line_peak_streamer_if: handshake between the line peak streamer (master) and the centroid finder (slave).
// Signals: cf_start, cf_max_pos, cf_max_value, cf_data_valid, cf_addr and cf_value go master->slave.
// cf_done and cf_result go slave->master.
interface line_peak_streamer_if #(
  parameter int ADDR_W = 9,
  parameter int PIX_W  = 10
);
  logic              cf_start;
  logic [ADDR_W-1:0] cf_max_pos;
  logic [PIX_W-1:0]  cf_max_value;
  logic              cf_data_valid;
  logic [ADDR_W-1:0] cf_addr;
  logic [PIX_W-1:0]  cf_value;
  logic              cf_done;
  logic [15:0]       cf_result;
  modport master (
    output cf_start, cf_max_pos, cf_max_value, cf_data_valid, cf_addr, cf_value,
    input  cf_done, cf_result
  );
  modport slave (
    input  cf_start, cf_max_pos, cf_max_value, cf_data_valid, cf_addr, cf_value,
    output cf_done, cf_result
  );
endinterface

// File: rtl/line_peak_streamer.sv
// line_peak_streamer: scans a captured line for its peak, then streams it to the centroid finder and latches the result.
// Ports: clk/rst_n (sync, active-low); frame_ready in / frame_release out to line capture;
// buf_addr out / buf_data in (data 1 cycle after address) to the line buffer;
// cf (master modport) to the centroid finder; result/result_valid, busy, timeout_err, overrun_cnt to the host.
module line_peak_streamer #(
  parameter int N_PIX        = 512,
  parameter int ADDR_W       = 9,
  parameter int PIX_W        = 10,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_ready,
  output logic                 frame_release,
  output logic [ADDR_W-1:0]    buf_addr,
  input  logic [PIX_W-1:0]     buf_data,
  line_peak_streamer_if.master cf,
  output logic [15:0]          result,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [7:0]           overrun_cnt
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SCAN, START, STREAM, TAIL, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d, rd_addr_q, rd_addr_d, next_addr;
  logic [ADDR_W-1:0] max_pos_q, max_pos_d, cf_max_pos_q, cf_max_pos_d, cf_addr_q, cf_addr_d;
  logic [PIX_W-1:0]  max_val_q, max_val_d, cf_max_value_q, cf_max_value_d, cf_value_q, cf_value_d;
  logic              rd_v_q, rd_v_d, cf_start_q, cf_start_d, cf_data_valid_q, cf_data_valid_d;
  logic              frame_release_q, frame_release_d, result_valid_q, result_valid_d;
  logic              timeout_err_q, timeout_err_d, last_rd;
  logic [15:0]       result_q, result_d;
  logic [7:0]        overrun_q, overrun_d;
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  // rd_v/rd_addr track the read issued last cycle, i.e. which pixel buf_data holds now.
  assign last_rd   = rd_v_q && rd_addr_q == LAST;
  assign next_addr = buf_addr_q == LAST ? '0 : buf_addr_q + ADDR_W'(1);
  always_comb begin
    state_d         = state_q;
    buf_addr_d      = '0;
    rd_v_d          = 1'b0;
    rd_addr_d       = buf_addr_q;
    max_pos_d       = max_pos_q;
    max_val_d       = max_val_q;
    cf_max_pos_d    = cf_max_pos_q;
    cf_max_value_d  = cf_max_value_q;
    cf_start_d      = 1'b0;
    cf_data_valid_d = 1'b0;
    cf_addr_d       = '0;
    cf_value_d      = '0;
    frame_release_d = 1'b0;
    result_d        = result_q;
    result_valid_d  = 1'b0;
    timeout_err_d   = timeout_err_q;
    wait_cnt_d      = '0;
    overrun_d       = (frame_ready && state_q != IDLE && overrun_q != '1) ? overrun_q + 8'd1 : overrun_q;
    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          state_d       = SCAN;
          max_pos_d     = '0;
          max_val_d     = '0;
          timeout_err_d = 1'b0;
        end
      end
      SCAN: begin
        // Strict > keeps the first occurrence on ties.
        if (rd_v_q && buf_data > max_val_q) begin
          max_pos_d = rd_addr_q;
          max_val_d = buf_data;
        end
        if (last_rd) begin
          state_d        = START;
          cf_start_d     = 1'b1;
          cf_max_pos_d   = max_pos_d;
          cf_max_value_d = max_val_d;
        end else begin
          rd_v_d     = 1'b1;
          buf_addr_d = next_addr;
        end
      end
      START: begin
        state_d    = STREAM;
        rd_v_d     = 1'b1;
        buf_addr_d = ADDR_W'(1);
      end
      STREAM: begin
        cf_data_valid_d = rd_v_q;
        cf_addr_d       = rd_addr_q;
        cf_value_d      = rd_v_q ? buf_data : '0;
        if (last_rd) begin
          state_d         = TAIL;
          frame_release_d = 1'b1;
        end else begin
          rd_v_d     = 1'b1;
          buf_addr_d = next_addr;
        end
      end
      TAIL: begin
        // Parking on the last address guarantees the centroid end condition fires.
        state_d   = WAIT_DONE;
        cf_addr_d = LAST;
      end
      WAIT_DONE: begin
        cf_addr_d = LAST;
        if (cf.cf_done) begin
          state_d        = IDLE;
          cf_addr_d      = '0;
          result_d       = cf.cf_result;
          result_valid_d = 1'b1;
        end else if (wait_cnt_q == TW'(DONE_TIMEOUT - 1)) begin
          state_d       = IDLE;
          cf_addr_d     = '0;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      buf_addr_q      <= '0;
      rd_v_q          <= 1'b0;
      rd_addr_q       <= '0;
      max_pos_q       <= '0;
      max_val_q       <= '0;
      cf_max_pos_q    <= '0;
      cf_max_value_q  <= '0;
      cf_start_q      <= 1'b0;
      cf_data_valid_q <= 1'b0;
      cf_addr_q       <= '0;
      cf_value_q      <= '0;
      frame_release_q <= 1'b0;
      result_q        <= '0;
      result_valid_q  <= 1'b0;
      timeout_err_q   <= 1'b0;
      wait_cnt_q      <= '0;
      overrun_q       <= '0;
    end else begin
      state_q         <= state_d;
      buf_addr_q      <= buf_addr_d;
      rd_v_q          <= rd_v_d;
      rd_addr_q       <= rd_addr_d;
      max_pos_q       <= max_pos_d;
      max_val_q       <= max_val_d;
      cf_max_pos_q    <= cf_max_pos_d;
      cf_max_value_q  <= cf_max_value_d;
      cf_start_q      <= cf_start_d;
      cf_data_valid_q <= cf_data_valid_d;
      cf_addr_q       <= cf_addr_d;
      cf_value_q      <= cf_value_d;
      frame_release_q <= frame_release_d;
      result_q        <= result_d;
      result_valid_q  <= result_valid_d;
      timeout_err_q   <= timeout_err_d;
      wait_cnt_q      <= wait_cnt_d;
      overrun_q       <= overrun_d;
    end
  end
  assign buf_addr         = buf_addr_q;
  assign frame_release    = frame_release_q;
  assign cf.cf_start      = cf_start_q;
  assign cf.cf_max_pos    = cf_max_pos_q;
  assign cf.cf_max_value  = cf_max_value_q;
  assign cf.cf_data_valid = cf_data_valid_q;
  assign cf.cf_addr       = cf_addr_q;
  assign cf.cf_value      = cf_value_q;
  assign result           = result_q;
  assign result_valid     = result_valid_q;
  assign busy             = state_q != IDLE;
  assign timeout_err      = timeout_err_q;
  assign overrun_cnt      = overrun_q;
endmodule

// File: tb/tb_line_peak_streamer.sv
// tb_line_peak_streamer: directed frames with a scoreboard of expected start/release/result/timeout events.
module tb_line_peak_streamer;
  localparam int N = 512;
  localparam logic [1:0] K_START = 2'd0, K_REL = 2'd1, K_RES = 2'd2, K_TO = 2'd3;
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, frame_ready = 1'b0;
  logic        frame_release, result_valid, busy, timeout_err;
  logic [8:0]  buf_addr;
  logic [9:0]  buf_data = '0;
  logic [15:0] result;
  logic [7:0]  overrun_cnt;
  logic [9:0]  mem [N];
  logic        done_en = 1'b1;
  logic [15:0] model_res = '0;
  int          dly = -1;
  int          checks = 0, errors = 0, cyc = 0, fr_cyc = 0, st_cyc = 0;
  exp_t        q[$];
  line_peak_streamer_if ifc ();
  line_peak_streamer dut (
    .clk(clk), .rst_n(rst_n), .frame_ready(frame_ready), .frame_release(frame_release),
    .buf_addr(buf_addr), .buf_data(buf_data), .cf(ifc.master), .result(result),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) buf_data <= mem[buf_addr];
  // Centroid finder model: done clears on start, rises a few cycles after the last beat.
  always @(posedge clk) begin
    if (!rst_n || ifc.cf_start) begin
      ifc.cf_done   <= 1'b0;
      ifc.cf_result <= '0;
      dly           <= -1;
    end else if (ifc.cf_data_valid && ifc.cf_addr == 9'(N - 1) && done_en) dly <= 4;
    else if (dly > 0) dly <= dly - 1;
    else if (dly == 0) begin
      ifc.cf_done   <= 1'b1;
      ifc.cf_result <= model_res;
      dly           <= -1;
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic expect_ev(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    q.push_back(e);
  endtask
  task automatic pop(input logic [1:0] k, output exp_t e);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d seen, scoreboard empty", k);
      e = '0;
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(k), 64'(e.kind));
    end
  endtask
  int nbeat = 0, beat_bad = 0, early_bad = 0;
  bit pre = 0, tail_pend = 0, prev_busy = 0, prev_to = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      nbeat = 0; beat_bad = 0; early_bad = 0;
      pre = 0; tail_pend = 0; prev_busy = 0; prev_to = 0;
    end else begin
      if (busy && !prev_busy) pre = 1;
      if (pre && ifc.cf_addr == 9'(N - 1)) early_bad++;
      if (tail_pend) begin
        chk("tail_addr", 64'(ifc.cf_addr), 64'(N - 1));
        chk("tail_valid_value", 64'({ifc.cf_data_valid, ifc.cf_value}), 64'(0));
        tail_pend = 0;
      end
      if (ifc.cf_start) begin
        pop(K_START, me);
        chk("max_pos", 64'(ifc.cf_max_pos), 64'(me.a));
        chk("max_value", 64'(ifc.cf_max_value), 64'(me.b));
        chk("start_latency", 64'(cyc - fr_cyc), 64'(514));
        st_cyc = cyc; nbeat = 0; beat_bad = 0;
      end
      if (ifc.cf_data_valid) begin
        pre = 0;
        if (ifc.cf_addr != 9'(nbeat) || ifc.cf_value != mem[ifc.cf_addr]) beat_bad++;
        nbeat++;
      end
      if (frame_release) begin
        pop(K_REL, me);
        chk("beat_count", 64'(nbeat), 64'(N));
        chk("beat_order_value", 64'(beat_bad), 64'(0));
        chk("addr_last_before_stream", 64'(early_bad), 64'(0));
        chk("release_at_last_beat", 64'({ifc.cf_data_valid, ifc.cf_addr}), 64'({1'b1, 9'(N - 1)}));
        early_bad = 0; tail_pend = 1;
      end
      if (result_valid) begin
        pop(K_RES, me);
        chk("result", 64'(result), 64'(me.a));
      end
      if (timeout_err && !prev_to) begin
        pop(K_TO, me);
        chk("timeout_result_kept", 64'(result), 64'(me.a));
        chk("timeout_latency", 64'(cyc - st_cyc), 64'(769));
      end
      prev_busy = busy; prev_to = timeout_err;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill(input logic [9:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask
  task automatic pulse_ready();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask
  task automatic start_frame();
    fr_cyc = cyc;
    pulse_ready();
  endtask
  task automatic wait_start();
    int n = 0;
    while (!ifc.cf_start && n < 1000) begin tick(); n++; end
    chk("start_seen", 64'(ifc.cf_start), 64'(1));
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    chk("frame_completes", 64'(busy), 64'(0));
    repeat (3) tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    fill('0);
    repeat (3) tick();
    chk("rst_host", 64'({busy, frame_release, buf_addr, result, result_valid, timeout_err, overrun_cnt}), 64'(0));
    chk("rst_cf", 64'({ifc.cf_start, ifc.cf_max_pos, ifc.cf_max_value, ifc.cf_data_valid, ifc.cf_addr, ifc.cf_value}), 64'(0));
    rst_n = 1'b1;
    tick();
    // A: ramp peaking at 800 on pixel 200
    for (int i = 0; i < 9; i++) mem[196 + i] = 10'(800 - 100 * (i < 4 ? 4 - i : i - 4));
    model_res = 16'h6400;
    expect_ev(K_START, 16'd200, 16'd800); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h6400, 0);
    start_frame();
    wait_idle();
    chk("max_pos_held", 64'(ifc.cf_max_pos), 64'(200));
    // B: equal peaks, first one wins
    fill('0); mem[40] = 10'd500; mem[100] = 10'd499; mem[300] = 10'd500;
    model_res = 16'h1234;
    expect_ev(K_START, 16'd40, 16'd500); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h1234, 0);
    start_frame();
    wait_idle();
    // C: all-zero line
    fill('0);
    model_res = 16'h0000;
    expect_ev(K_START, 16'd0, 16'd0); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h0000, 0);
    start_frame();
    wait_idle();
    // D: three overrun pulses during the stream
    for (int i = 0; i < N; i++) mem[i] = 10'(i % 100);
    model_res = 16'h0ABC;
    expect_ev(K_START, 16'd99, 16'd99); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h0ABC, 0);
    start_frame();
    wait_start();
    repeat (50) tick();
    for (int i = 0; i < 3; i++) begin pulse_ready(); repeat (7) tick(); end
    wait_idle();
    chk("overrun_3", 64'(overrun_cnt), 64'(3));
    // E: done never comes; peak on last pixel; frame_ready in the WAIT_DONE exit cycle
    fill('0); mem[0] = 10'd1022; mem[511] = 10'd1023;
    done_en = 1'b0;
    expect_ev(K_START, 16'd511, 16'd1023); expect_ev(K_REL, 0, 0); expect_ev(K_TO, 16'h0ABC, 0);
    start_frame();
    wait_start();
    repeat (768) tick();
    pulse_ready();
    chk("exit_ready_not_accepted", 64'(busy), 64'(0));
    chk("exit_ready_overrun", 64'(overrun_cnt), 64'(4));
    chk("timeout_set", 64'(timeout_err), 64'(1));
    chk("timeout_no_new_result", 64'(result), 64'(16'h0ABC));
    repeat (3) tick();
    // F: next accepted frame clears timeout_err; peak on pixel 0
    done_en = 1'b1;
    fill(10'd100); mem[0] = 10'd700;
    model_res = 16'h5555;
    expect_ev(K_START, 16'd0, 16'd700); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h5555, 0);
    start_frame();
    chk("timeout_cleared", 64'({busy, timeout_err}), 64'(2'b10));
    wait_idle();
    // G: reset at stream beat 100
    for (int i = 0; i < N; i++) mem[i] = 10'(i);
    expect_ev(K_START, 16'd511, 16'd511);
    start_frame();
    wait_start();
    n = 0;
    while (!(ifc.cf_data_valid && ifc.cf_addr == 9'd100) && n < 200) begin tick(); n++; end
    chk("beat_100_seen", 64'({ifc.cf_data_valid, ifc.cf_addr}), 64'({1'b1, 9'd100}));
    rst_n = 1'b0;
    tick();
    chk("midrst_host", 64'({busy, frame_release, buf_addr, result, result_valid, timeout_err, overrun_cnt}), 64'(0));
    chk("midrst_cf", 64'({ifc.cf_start, ifc.cf_max_pos, ifc.cf_max_value, ifc.cf_data_valid, ifc.cf_addr, ifc.cf_value}), 64'(0));
    rst_n = 1'b1;
    tick();
    // H: full frame after reset, tie at the last two pixels
    fill('0); mem[510] = 10'd900; mem[511] = 10'd900;
    model_res = 16'h7777;
    expect_ev(K_START, 16'd510, 16'd900); expect_ev(K_REL, 0, 0); expect_ev(K_RES, 16'h7777, 0);
    start_frame();
    wait_idle();
    chk("overrun_after_reset", 64'(overrun_cnt), 64'(0));
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/line_peak_streamer.md
Name: line_peak_streamer

Overview:
- Producer side of the centroid interface: reads one captured CCD line from the line buffer and finds its peak position and value.
- Pulses start to the centroid block, then streams the line as address/value/data_valid beats.
- Waits for the centroid block's done and latches the 16-bit centroid result for the host/UART path.
- Sits between line capture (buffer writer) and the centroid finder.

Parameters:
- N_PIX, 512, pixels per line; last address = N_PIX-1.
- ADDR_W, 9, pixel address width.
- PIX_W, 10, pixel value width.
- DONE_TIMEOUT, 255, max cycles in WAIT_DONE before the error exit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- frame_ready  in  1  one-cycle pulse: line buffer holds a complete line.
- frame_release  out  1  one-cycle pulse: buffer reads finished, capture may overwrite.
- buf_addr  out  ADDR_W  line buffer read address.
- buf_data  in  PIX_W  line buffer read data, valid exactly 1 cycle after buf_addr.
- cf_start  out  1  start pulse to centroid finder.
- cf_max_pos  out  ADDR_W  peak position, stable from cf_start until next frame.
- cf_max_value  out  PIX_W  peak value, same stability as cf_max_pos.
- cf_data_valid  out  1  stream beat qualifier.
- cf_addr  out  ADDR_W  pixel address of the current beat.
- cf_value  out  PIX_W  pixel value of the current beat.
- cf_done  in  1  centroid done level; cleared by cf_start.
- cf_result  in  16  centroid result, valid while cf_done=1.
- result  out  16  latched centroid.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky; set by done timeout, cleared by next accepted frame_ready.
- overrun_cnt  out  8  saturating count of frame_ready pulses ignored while busy.

Behaviour:
- Reset (rst_n=0 at clk edge) applies from any state, including mid-stream:
  - state returns to IDLE;
  - all outputs go to 0, including result, cf_max_*, cf_addr, timeout_err and overrun_cnt.
- States: IDLE -> SCAN -> START -> STREAM -> TAIL -> WAIT_DONE -> IDLE.
- IDLE:
  - cf_addr is held at 0 and cf_data_valid=0.
  - frame_ready=1 moves to SCAN, resets the max tracker to pos=0/value=0, and clears timeout_err.
- SCAN:
  - buf_addr steps 0..N_PIX-1, one per cycle.
  - Each returned buf_data is compared to the tracked max with strict >, so the first occurrence wins ties.
  - The final sample is compared in the cycle after buf_addr=N_PIX-1, then the block moves to START.
  - cf_addr stays 0 throughout. This is mandatory: the centroid end flag fires on address N_PIX-1, so that address must never be presented while start is active or before the stream begins.
- START:
  - cf_start=1 for exactly one cycle.
  - cf_max_pos/cf_max_value are updated in that same cycle and then held.
  - buf_addr=0 is issued, and the block moves to STREAM.
  - cf_start occurs N_PIX+2 cycles after the frame_ready edge is accepted.
- STREAM:
  - buf_addr advances 1..N_PIX-1 each cycle.
  - Outputs are registered: cf_addr/cf_value/cf_data_valid present the buffer output 1 cycle after its read.
  - cf_data_valid=1 for exactly N_PIX consecutive cycles, beginning the 2nd cycle after cf_start.
  - cf_addr is 0..N_PIX-1 in ascending order with no gaps.
  - frame_release pulses in the cycle the last beat is presented.
- TAIL:
  - cf_addr is held at N_PIX-1 with cf_data_valid=0 and cf_value=0, for at least 1 cycle and until return to IDLE.
  - This guarantees the centroid end condition even when pixel N_PIX-1 was accepted.
  - The block moves to WAIT_DONE after 1 cycle.
- WAIT_DONE:
  - A cycle counter starts at 0.
  - cf_done=1 latches cf_result into result, pulses result_valid, and returns to IDLE (cf_addr returns to 0).
  - If the counter reaches DONE_TIMEOUT first: set timeout_err, leave result unchanged, no result_valid, go to IDLE.
- frame_ready while busy is ignored; overrun_cnt increments and saturates at 255.
- Simultaneous frame_ready and the WAIT_DONE exit: the pulse counts as an overrun, because busy is still high in that cycle.
- Widths:
  - the max tracker is PIX_W;
  - position is ADDR_W;
  - the address counter terminates explicitly at N_PIX-1 and must not rely on wrap.

Test Plan:
- Line with a ramp peak value 800 at pixel 200, zero elsewhere -> cf_max_pos=200 and cf_max_value=800 at cf_start, 514 cycles after frame_ready. The bench centroid model is then fed cf_result=0x6400 at done; result=0x6400 and result_valid pulses once.
- Two equal peaks of 500 at pixels 40 and 300 -> cf_max_pos=40. Exactly 512 valid beats, cf_addr 0..511 in order, then cf_addr=511 with data_valid=0.
- All-zero line -> cf_max_pos=0 and cf_max_value=0. cf_addr is never 511 before the stream, and a centroid model echoing 0 gives result=0.
- Three frame_ready pulses during STREAM -> overrun_cnt=3, and the stream completes unperturbed.
- cf_done held low -> timeout_err=1 after 255 WAIT_DONE cycles, result unchanged, no result_valid; the next frame_ready clears timeout_err.
- rst_n low for 1 cycle at stream beat 100 -> all outputs 0 the next cycle and state IDLE. A following frame_ready runs a complete correct frame.
